// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Round-robin owner of the enable pins of N tri-state buffers sharing one
//   wire. At most one grant at a time, bounded tenure under competition, and
//   TURN_CYCLES all-low cycles between two owners so drivers never overlap.
// Ports:
//   clk_i    - clock, all state changes on rising edge
//   rst_ni   - synchronous active-low reset
//   req_i    - per-driver level request, held while the bus is wanted
//   grant_o  - registered one-hot-or-zero buffer enables (to buffer en pins)
//   busy_o   - grant_o != 0
//   owner_o  - index of the granted requester, 0 when not busy
module tristate_bus_arbiter #(
  parameter int N           = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         grant_o,
  output logic                 busy_o,
  output logic [$clog2(N)-1:0] owner_o
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic [TW-1:0]   turn_q,  turn_d;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [N-1:0]    others;
  logic            release_c, preempt_c;

  // Rotating priority scan: walk offsets high to low so the smallest offset
  // from ptr (the highest priority) is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr_q) + i) % N;
      if (req_i[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  assign others    = req_i & ~grant_q;
  assign release_c = ~req_i[owner_q];
  assign preempt_c = (hold_q == HW'(MAX_HOLD)) && (others != '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          hold_d           = HW'(1);
        end
      end
      GRANT: begin
        // Release and pre-emption at the same edge collapse into one entry.
        if (release_c || preempt_c) begin
          state_d = TURN;
          grant_d = '0;
          owner_d = '0;
          ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
          turn_d  = TW'(TURN_CYCLES - 1);
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q != '0) begin
          turn_d = turn_q - TW'(1);
        end else if (win_vld) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          hold_d           = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign busy_o  = |grant_q;

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that owns the enable inputs of the `cmos_tri_state_buffer` instances sharing one bus wire. It grants the bus to at most one requester at a time and bounds each tenure. It inserts a programmable turnaround gap, with all enables low, between owners so that two buffers never drive the wire in the same cycle. Each `grant` bit connects directly to the `en` pin of the corresponding tri-state buffer.

## Interface
- `N`, 4, number of requesters / tri-state drivers; N >= 2
- `MAX_HOLD`, 8, maximum consecutive grant cycles while another requester waits; >= 1
- `TURN_CYCLES`, 1, all-enables-low cycles between two different grants; >= 1
- `clk`  input  1  single clock, all state changes on rising edge
- `rst_n`  input  1  synchronous, active-low reset
- `req`  input  N  request per driver, level-sensitive, held while bus wanted
- `grant`  output  N  one-hot-or-zero buffer enables, registered
- `busy`  output  1  `grant != 0`
- `owner`  output  $clog2(N)  index of granted requester; valid only when `busy`=1, else 0

## Operation
- Reset (`rst_n`=0 at an edge) forces the following state:
  - `grant`=0, `busy`=0, `owner`=0
  - state=IDLE, priority pointer `ptr`=0, `hold_cnt`=0, `turn_cnt`=0
- Reset applies at the next edge even mid-grant or mid-turnaround.
- Arbitration picks the first set bit of `req` scanning `ptr`, `ptr+1`, ... mod N.
- States:
  - IDLE:
    - If `req` != 0: load `grant`/`owner` with the winner, `hold_cnt`=1, go to GRANT.
    - Else stay in IDLE.
  - GRANT, evaluated each edge with `o`=`owner`:
    - `req[o]`=0: go to TURN.
    - `hold_cnt`==MAX_HOLD and (`req` with bit `o` cleared) != 0: go to TURN (pre-emption).
    - Otherwise stay; `hold_cnt` <= min(`hold_cnt`+1, MAX_HOLD), saturating.
    - A lone requester therefore keeps the bus indefinitely.
  - Entering TURN:
    - `grant`=0, `owner`=0.
    - `ptr` <= (`o`+1) mod N.
    - `turn_cnt`=TURN_CYCLES-1.
  - TURN:
    - If `turn_cnt`!=0: decrement and stay.
    - If `turn_cnt`==0 and `req`!=0: arbitrate from `ptr`, go to GRANT, `hold_cnt`=1.
    - If `turn_cnt`==0 and `req`==0: go to IDLE.
- Invariants:
  - `grant` is always $onehot0.
  - A grant is never handed directly from one owner to another without TURN_CYCLES zero cycles in between.
  - From IDLE, no gap is inserted because the bus is already undriven.
- The previous owner may win again after TURN only if no other requester is set, because `ptr` has moved past it.
- Requests that rise and fall while not granted are not remembered; there is no request latch.
- Widths:
  - `hold_cnt`: $clog2(MAX_HOLD+1) bits.
  - `turn_cnt`: $clog2(TURN_CYCLES) bits, minimum 1.
  - `ptr` and `owner`: $clog2(N) bits, with explicit wrap at N for non-power-of-two N.

## Timing
- Request to grant from IDLE: `req` sampled at edge e, `grant` high in the cycle after e (1-cycle latency).
- Release: `req[o]` low at edge e, `grant` low in the cycle after e.
- With other requests pending, the next grant rises after exactly TURN_CYCLES zero cycles.
- Pre-emption: under continuous competition the owner holds `grant` exactly MAX_HOLD cycles.
- Pre-emption tenure, period and rotation:
  - Tenure plus gap gives a period of MAX_HOLD+TURN_CYCLES cycles per owner.
  - Full rotation over N continuous requesters takes N*(MAX_HOLD+TURN_CYCLES) cycles.
- Release and pre-emption conditions true at the same edge: treated as one TURN entry.
- Reset released at edge e: the first arbitration happens at edge e+1.
- `busy` and `owner` change on the same edges as `grant`; all outputs are glitch-free registered signals.

## Test plan
- Reset with `req`=1111 held for 2 cycles: `grant`=0000, `busy`=0. The first edge after reset release gives `grant`=0001, `owner`=0.
- `req`=0100 alone for 20 cycles, MAX_HOLD=8: `grant`=0100 continuously with no gap and no pre-emption; dropping `req` gives `grant`=0000 next cycle and state IDLE.
- `req`=1111 constant, MAX_HOLD=8, TURN_CYCLES=1, checked from the first grant:
  - `grant` sequence: 0001 ×8, 0000 ×1, 0010 ×8, 0000, 0100 ×8, 0000, 1000 ×8, 0000, then back to 0001.
  - Rotation period: 36 cycles.
- `req`=0101 and requester 0 granted; drop `req[0]` after 3 grant cycles, then re-raise it during TURN: the next grant is 0100, not 0001, because `ptr` has moved to 1.
- `rst_n`=0 asserted in the 4th cycle of a grant to requester 2: `grant`=0000 on the next edge; after release with `req`=1111, the winner is requester 0.
- TURN_CYCLES=3 with `req`=0011 constant: exactly 3 zero cycles between the 0001 and 0010 tenures; an assertion on every cycle confirms `grant` is $onehot0 and never changes directly between two nonzero values.
